// File: rtl/xor_fold_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// xor_fold_arbiter : round-robin share of one XOR-fold checksum datapath.
// Optional idle timeout with res_err output: define XOR_TIMEOUT_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
module xor_fold_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 8,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*WIDTH-1:0]  req_data,
  input  logic [NREQ-1:0]        req_last,
  output logic [NREQ-1:0]        req_ready,
  output logic                   res_valid,
  output logic [WIDTH-1:0]       res_data,
  output logic [IDW-1:0]         res_id,
  input  logic                   res_ready,
`ifdef XOR_TIMEOUT_EN
  output logic                   res_err,
`endif
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FOLD = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [IDW-1:0]   grant_q, grant_d;
  logic [IDW-1:0]   rr_q, rr_d;
  logic [IDW-1:0]   pick_w;
  logic             found_w;
  logic [IDW-1:0]   rr_next_w;
  logic [WIDTH-1:0] word_w [NREQ];

  if (IDW != $clog2(NREQ) || TIMEOUT < 1) begin : g_bad_params
    $error("xor_fold_arbiter: IDW must equal clog2(NREQ) and TIMEOUT must be >= 1");
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign word_w[g] = req_data[g*WIDTH +: WIDTH];
  end

`ifdef XOR_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] idle_q, idle_d;
  logic          err_q, err_d;
  assign res_err = err_q;
`endif

  // First requesting index at or above rr_q, wrapping past NREQ-1.
  always_comb begin
    pick_w  = rr_q;
    found_w = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found_w && req_valid[(int'(rr_q) + k) % NREQ]) begin
        found_w = 1'b1;
        pick_w  = IDW'((int'(rr_q) + k) % NREQ);
      end
    end
  end

  assign rr_next_w = (grant_q == IDW'(NREQ - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    grant_d = grant_q;
    rr_d    = rr_q;
`ifdef XOR_TIMEOUT_EN
    idle_d  = idle_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (found_w) begin
          grant_d = pick_w;
          acc_d   = '0;
          state_d = FOLD;
`ifdef XOR_TIMEOUT_EN
          idle_d  = '0;
`endif
        end
      end
      FOLD: begin
        if (req_valid[grant_q]) begin
          acc_d = acc_q ^ word_w[grant_q];
`ifdef XOR_TIMEOUT_EN
          idle_d = '0;
`endif
          if (req_last[grant_q]) state_d = DONE;
        end
`ifdef XOR_TIMEOUT_EN
        else if (idle_q == CW'(TIMEOUT - 1)) begin
          // Give up on a stalled burst and report what was folded so far.
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          idle_d = idle_q + 1'b1;
        end
`endif
      end
      DONE: begin
        if (res_ready) begin
          rr_d    = rr_next_w;
          state_d = IDLE;
`ifdef XOR_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      grant_q <= '0;
      rr_q    <= '0;
`ifdef XOR_TIMEOUT_EN
      idle_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
`ifdef XOR_TIMEOUT_EN
      idle_q  <= idle_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == FOLD) req_ready[grant_q] = 1'b1;
  end

  assign res_valid = (state_q == DONE);
  assign res_data  = (state_q == DONE) ? acc_q : '0;
  assign res_id    = (state_q == DONE) ? grant_q : '0;
  assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_xor_fold_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_xor_fold_arbiter : directed bench with a transaction-level reference model.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_xor_fold_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ*W-1:0] req_data = '0;
  logic [NREQ-1:0] req_last = '0;
  logic [NREQ-1:0] req_ready;
  logic            res_valid;
  logic [W-1:0]    res_data;
  logic [1:0]      res_id;
  logic            res_ready = 1'b0;
  logic            busy;
`ifdef XOR_TIMEOUT_EN
  logic            res_err;
`endif

  xor_fold_arbiter #(.NREQ(NREQ), .WIDTH(W), .IDW(2), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready),
    .res_valid(res_valid), .res_data(res_data), .res_id(res_id),
    .res_ready(res_ready),
`ifdef XOR_TIMEOUT_EN
    .res_err(res_err),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one burst in flight, tracked as owner + running XOR.
  bit       m_active, m_pending, m_err;
  int       m_owner, m_rr, m_idle;
  logic [7:0] m_sum;
  bit       tmo_en;

  initial begin
`ifdef XOR_TIMEOUT_EN
    tmo_en = 1'b1;
`else
    tmo_en = 1'b0;
`endif
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_active = 0; m_pending = 0; m_err = 0;
        m_owner = 0; m_rr = 0; m_idle = 0; m_sum = 8'h00;
      end else if (m_pending) begin
        if (res_ready) begin
          m_pending = 0; m_active = 0; m_err = 0;
          m_rr = (m_owner + 1) % NREQ;
        end
      end else if (m_active) begin
        if (req_valid[m_owner]) begin
          m_sum = m_sum ^ req_data[m_owner*W +: W];
          m_idle = 0;
          if (req_last[m_owner]) m_pending = 1;
        end else begin
          m_idle++;
          if (tmo_en && m_idle == 4) begin
            m_pending = 1; m_err = 1;
          end
        end
      end else if (req_valid != 0) begin
        for (int k = 0; k < NREQ; k++) begin
          if (!m_active && req_valid[(m_rr + k) % NREQ]) begin
            m_active = 1; m_owner = (m_rr + k) % NREQ;
          end
        end
        m_sum = 8'h00; m_idle = 0;
      end
    end
  end

  int log_id[$];
  int log_data[$];
  int log_err[$];
  int beats0 = 0;

  always @(negedge clk) begin
    logic [NREQ-1:0] exp_ready;
    exp_ready = (m_active && !m_pending) ? NREQ'(1 << m_owner) : '0;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("busy", 32'(busy), 32'(m_active));
    chk("res_valid", 32'(res_valid), 32'(m_pending));
    if (m_pending || !rst_n) begin
      chk("res_data", 32'(res_data), m_pending ? 32'(m_sum) : 32'h0);
      chk("res_id", 32'(res_id), m_pending ? 32'(m_owner) : 32'h0);
    end
`ifdef XOR_TIMEOUT_EN
    chk("res_err", 32'(res_err), 32'(m_err));
`endif
    if (req_valid[0] && req_ready[0]) beats0++;
    if (res_valid && res_ready) begin
      log_id.push_back(int'(res_id));
      log_data.push_back(int'(res_data));
`ifdef XOR_TIMEOUT_EN
      log_err.push_back(int'(res_err));
`else
      log_err.push_back(0);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic send(input int i, input logic [7:0] d, input bit last);
    int c = 0;
    req_valid[i] = 1'b1;
    req_data[i*W +: W] = d;
    req_last[i] = last;
    while (!req_ready[i] && c < 50) begin tick(); c++; end
    chk("send_grant", 32'(req_ready[i]), 32'h1);
    tick();
    req_valid[i] = 1'b0;
    req_last[i] = 1'b0;
  endtask

  // Single-beat bursts from every requester in mask, each dropped once accepted.
  task automatic run_multi(input logic [NREQ-1:0] mask);
    logic [NREQ-1:0] pend, took;
    int c = 0;
    pend = mask;
    for (int i = 0; i < NREQ; i++) begin
      if (mask[i]) begin
        req_valid[i] = 1'b1; req_last[i] = 1'b1;
      end
    end
    while (pend != 0 && c < 200) begin
      took = req_ready & req_valid;
      tick(); c++;
      req_valid = req_valid & ~took;
      req_last = req_last & ~took;
      pend = pend & ~took;
    end
    chk("multi_done", 32'(pend), 32'h0);
  endtask

  task automatic wait_log(input int n);
    int c = 0;
    while (log_id.size() < n && c < 200) begin tick(); c++; end
    chk("wait_result", 32'(log_id.size()), 32'(n));
  endtask

  task automatic chk_log(input int idx, input int id, input int data);
    if (idx < log_id.size()) begin
      chk("log_id", 32'(log_id[idx]), 32'(id));
      chk("log_data", 32'(log_data[idx]), 32'(data));
    end else begin
      chk("log_present", 32'(log_id.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    int base;
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    // Reset with random inputs on the pins
    rst_n = 1'b0;
    for (int n = 0; n < 4; n++) begin
      req_valid = NREQ'($urandom); req_last = NREQ'($urandom);
      req_data = $urandom; res_ready = 1'($urandom);
      tick();
    end
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_res_valid", 32'(res_valid), 32'h0);
    chk("rst_res_data", 32'(res_data), 32'h0);
    req_valid = '0; req_last = '0; req_data = '0; res_ready = 1'b1;
    rst_n = 1'b1;
    tick();

    // Single three-beat burst from requester 0
    beats0 = 0;
    send(0, 8'hA5, 0); send(0, 8'h0F, 0); send(0, 8'hFF, 1);
    wait_log(1);
    chk_log(0, 0, 8'h55);
    chk("beats0", 32'(beats0), 32'd3);

    // Round robin, twice, from a fresh rr pointer
    do_reset();
    for (int i = 0; i < NREQ; i++) req_data[i*W +: W] = 8'(1 << i);
    for (int r = 0; r < 2; r++) begin
      base = log_id.size();
      run_multi(4'hF);
      wait_log(base + 4);
      for (int i = 0; i < NREQ; i++) chk_log(base + i, i, 1 << i);
    end

    // Bubbles and result backpressure
    res_ready = 1'b0;
    base = log_id.size();
    send(2, 8'h11, 0);
    tick(); tick(); tick();
    send(2, 8'h22, 1);
    for (int n = 0; n < 5; n++) begin
      chk("stall_valid", 32'(res_valid), 32'h1);
      chk("stall_data", 32'(res_data), 32'h33);
      chk("stall_id", 32'(res_id), 32'h2);
      chk("stall_ready", 32'(req_ready), 32'h0);
      chk("stall_busy", 32'(busy), 32'h1);
      tick();
    end
    res_ready = 1'b1;
    tick();
    chk("post_hs_valid", 32'(res_valid), 32'h0);
    chk("post_hs_busy", 32'(busy), 32'h0);
    chk_log(base, 2, 8'h33);

    // Asynchronous reset in the middle of a burst
    send(1, 8'h3C, 0);
    base = log_id.size();
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_ready", 32'(req_ready), 32'h0);
    chk("async_rst_busy", 32'(busy), 32'h0);
    chk("async_rst_valid", 32'(res_valid), 32'h0);
    #1 rst_n = 1'b1;
    tick();
    req_data[1*W +: W] = 8'h5A;
    req_data[3*W +: W] = 8'hC3;
    run_multi(4'b1010);
    wait_log(base + 2);
    chk_log(base, 1, 8'h5A);
    chk_log(base + 1, 3, 8'hC3);
    tick(); tick();
    chk("no_stale_result", 32'(log_id.size()), 32'(base + 2));

`ifdef XOR_TIMEOUT_EN
    // Idle timeout on a burst that never sends last
    base = log_id.size();
    send(1, 8'h3C, 0);
    wait_log(base + 1);
    chk_log(base, 1, 8'h3C);
    if (base < log_err.size()) chk("tmo_err", 32'(log_err[base]), 32'h1);
    send(0, 8'h77, 1);
    wait_log(base + 2);
    chk_log(base + 1, 0, 8'h77);
    if (base + 1 < log_err.size()) chk("normal_err", 32'(log_err[base + 1]), 32'h0);
`endif

    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
